// File: rtl/core_gen2_if.sv
// core_gen2 memory bus: synchronous single-port main memory.
// The core (master) drives address, write strobe and write data; the memory
// (slave) returns read data one clk after the address is presented.
interface core_gen2_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/core_gen2.sv
// core_gen2: second-generation multi-cycle CPU core.
// FETCH -> DECODE -> EXEC (-> LOAD) sequencing, advanced only on ce.
// Eight registers, Z/N/C flags, bounded hardware stack with overflow/underflow
// fault, sticky HALT.
// Optional feature macro: CORE_GEN2_CALL_EN enables CALL (0xD) / RET (0xE);
// without it both opcodes execute as NOP.
module core_gen2 #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  core_gen2_if.master           bus,
  output logic                  halted,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] dbg_pc,
  output logic [2:0]            dbg_state
);
  localparam int W   = DATA_WIDTH;
  localparam int SPW = $clog2(STACK_DEPTH);
  localparam logic [SPW:0] SP_FULL = (SPW+1)'(STACK_DEPTH);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_PUSH = 4'hA;
  localparam logic [3:0] OP_POP  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
`ifdef CORE_GEN2_CALL_EN
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_LOAD   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Architectural and pipeline state
  logic [W-1:0]          regs  [8];
  logic [W-1:0]          stack [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] pc;
  logic [SPW:0]          sp;
  logic                  flag_z, flag_n, flag_c;
  logic [W-1:0]          instr;
  logic [W-1:0]          opa, opb;

  // Instruction fields
  logic [3:0]            op;
  logic [2:0]            ra;
  logic [W-1:0]          imm;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [SPW-1:0]        push_idx, pop_idx;

  assign op       = instr[W-1:W-4];
  assign ra       = instr[W-5:W-7];
  assign imm      = W'(instr[W-8:0]);
  assign pc_inc   = pc + ADDR_WIDTH'(1);
  assign push_idx = sp[SPW-1:0];
  assign pop_idx  = sp[SPW-1:0] - SPW'(1);

  // Control strobes and next values produced by the output process
  logic                  stack_fault;
  logic                  cond_true;
  logic                  instr_load;
  logic                  reg_we;
  logic [2:0]            reg_wsel;
  logic [W-1:0]          reg_wdata;
  logic                  flags_we;
  logic                  z_nxt, n_nxt, c_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [SPW:0]          sp_nxt;
  logic                  stack_we;
  logic [W-1:0]          stack_wdata;
  logic                  mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [W-1:0]          mem_wdata_nxt;
  logic                  halt_set;
  logic [W-1:0]          alu_res;
  logic                  alu_c;

  assign dbg_pc    = pc;
  assign dbg_state = state;

  // Stack overflow/underflow detection for the instruction in EXEC
  always_comb begin
    stack_fault = 1'b0;
    if (state == S_EXEC) begin
      case (op)
        OP_PUSH: stack_fault = (sp == SP_FULL);
        OP_POP:  stack_fault = (sp == '0);
`ifdef CORE_GEN2_CALL_EN
        OP_CALL: stack_fault = (sp == SP_FULL);
        OP_RET:  stack_fault = (sp == '0);
`endif
        default: stack_fault = 1'b0;
      endcase
    end else begin
      stack_fault = 1'b0;
    end
  end

  // Branch condition evaluation; the condition code sits in the ra field
  always_comb begin
    cond_true = 1'b0;
    case (ra)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flag_z;
      3'd2:    cond_true = !flag_z;
      3'd3:    cond_true = flag_n;
      3'd4:    cond_true = !flag_n;
      3'd5:    cond_true = flag_c;
      3'd6:    cond_true = !flag_c;
      default: cond_true = 1'b0;
    endcase
  end

  // ALU: C is carry-out for ADD, no-borrow for SUB, cleared by logic ops
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:  {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
      OP_SUB:  begin alu_res = opa - opb; alu_c = (opa >= opb); end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      default: begin alu_res = '0; alu_c = 1'b0; end
    endcase
  end

  // FSM state register; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_HALT || stack_fault) state_nxt = S_HALT;
        else if (op == OP_LD)             state_nxt = S_LOAD;
        else                              state_nxt = S_FETCH;
      end
      S_LOAD:   state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // FSM output logic: per-state datapath controls; a faulting stack op changes nothing
  always_comb begin
    instr_load    = 1'b0;
    reg_we        = 1'b0;
    reg_wsel      = ra;
    reg_wdata     = '0;
    flags_we      = 1'b0;
    z_nxt         = (alu_res == '0);
    n_nxt         = alu_res[W-1];
    c_nxt         = alu_c;
    pc_nxt        = pc;
    sp_nxt        = sp;
    stack_we      = 1'b0;
    stack_wdata   = opa;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = bus.mem_addr;
    mem_wdata_nxt = bus.mem_wdata;
    halt_set      = 1'b0;
    case (state)
      S_FETCH:  mem_addr_nxt = pc;
      S_DECODE: instr_load = 1'b1;
      S_EXEC: begin
        if (stack_fault) begin
          halt_set = 1'b1;
        end else begin
          pc_nxt = pc_inc;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              reg_we    = 1'b1;
              reg_wdata = alu_res;
              flags_we  = 1'b1;
            end
            OP_MOV: begin reg_we = 1'b1; reg_wdata = opb; end
            OP_LDI: begin reg_we = 1'b1; reg_wdata = imm; end
            OP_LD:  mem_addr_nxt = opb[ADDR_WIDTH-1:0];
            OP_ST: begin
              mem_we_nxt    = 1'b1;
              mem_addr_nxt  = opb[ADDR_WIDTH-1:0];
              mem_wdata_nxt = opa;
            end
            OP_PUSH: begin stack_we = 1'b1; sp_nxt = sp + (SPW+1)'(1); end
            OP_POP: begin
              reg_we    = 1'b1;
              reg_wdata = stack[pop_idx];
              sp_nxt    = sp - (SPW+1)'(1);
            end
            OP_JMP: pc_nxt = cond_true ? opb[ADDR_WIDTH-1:0] : pc_inc;
`ifdef CORE_GEN2_CALL_EN
            OP_CALL: begin
              stack_we    = 1'b1;
              stack_wdata = W'(pc_inc);
              sp_nxt      = sp + (SPW+1)'(1);
              pc_nxt      = opb[ADDR_WIDTH-1:0];
            end
            OP_RET: begin
              pc_nxt = stack[pop_idx][ADDR_WIDTH-1:0];
              sp_nxt = sp - (SPW+1)'(1);
            end
`endif
            OP_HALT: begin pc_nxt = pc; halt_set = 1'b1; end
            default: pc_nxt = pc_inc;
          endcase
        end
      end
      S_LOAD: begin reg_we = 1'b1; reg_wdata = bus.mem_rdata; end
      S_HALT: pc_nxt = pc;
      default: pc_nxt = pc;
    endcase
  end

  // Datapath and output registers; mem_we self-clears even while ce is low
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= '0;
      sp            <= '0;
      flag_z        <= 1'b0;
      flag_n        <= 1'b0;
      flag_c        <= 1'b0;
      instr         <= '0;
      opa           <= '0;
      opb           <= '0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (ce) begin
        bus.mem_we    <= mem_we_nxt;
        bus.mem_addr  <= mem_addr_nxt;
        bus.mem_wdata <= mem_wdata_nxt;
        pc            <= pc_nxt;
        sp            <= sp_nxt;
        if (instr_load) begin
          instr <= bus.mem_rdata;
          opa   <= regs[bus.mem_rdata[W-5:W-7]];
          opb   <= regs[bus.mem_rdata[W-8:W-10]];
        end
        if (reg_we) regs[reg_wsel] <= reg_wdata;
        if (flags_we) begin
          flag_z <= z_nxt;
          flag_n <= n_nxt;
          flag_c <= c_nxt;
        end
        if (halt_set) halted <= 1'b1;
        if (stack_fault) fault <= 1'b1;
      end
    end
  end

  // Stack storage; entries at or above sp are never read, so no reset is needed
  always_ff @(posedge clk) begin
    if (!reset && ce && stack_we) stack[push_idx] <= stack_wdata;
  end
endmodule

// File: tb/tb_core_gen2.sv
// Directed testbench for core_gen2 (DATA_WIDTH=12, ADDR_WIDTH=8, STACK_DEPTH=4).
module tb_core_gen2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       halted, fault;
  logic [7:0] dbg_pc;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;

  core_gen2_if #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) bus ();

  core_gen2 #(.DATA_WIDTH(12), .ADDR_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus),
    .halted(halted), .fault(fault), .dbg_pc(dbg_pc), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory model with a bench-side load port
  logic [11:0] mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_waddr = 8'd0;
  logic [11:0] tb_wdata = 12'd0;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) we_cnt <= we_cnt + 1;
  end

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
    return {op, a, b, 2'b00};
  endfunction

  function automatic logic [11:0] ldi(input logic [2:0] a, input logic [4:0] imm);
    return {4'h7, a, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [11:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) wr(8'(i), 12'h000);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ce = 1'b1;
      @(negedge clk); ce = 1'b0;
    end
    @(negedge clk);
  endtask

  int we_before;

  initial begin
    // ---- reset state ----
    clear_mem();
    do_reset();
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_pc", 32'(dbg_pc), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    chk("rst_we", 32'(bus.mem_we), 32'h0);
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);

    // ---- LDI/ADD/HALT ----
    wr(8'd0, ldi(3'd1, 5'd31));
    wr(8'd1, ldi(3'd2, 5'd1));
    wr(8'd2, ins(4'h1, 3'd1, 3'd2));
    wr(8'd3, ins(4'hF, 3'd0, 3'd0));
    do_reset();
    pulse(11);
    chk("add_halted_11", 32'(halted), 32'h0);
    chk("add_state_11", 32'(dbg_state), 32'h2);
    pulse(1);
    chk("add_halted_12", 32'(halted), 32'h1);
    chk("add_state_12", 32'(dbg_state), 32'h4);
    chk("add_pc", 32'(dbg_pc), 32'h3);
    chk("add_r1", 32'(dut.regs[1]), 32'h020);
    chk("add_zcn", 32'({dut.flag_z, dut.flag_n, dut.flag_c}), 32'h0);
    chk("add_fault", 32'(fault), 32'h0);
    pulse(2);
    chk("halt_sticky_state", 32'(dbg_state), 32'h4);
    chk("halt_sticky_pc", 32'(dbg_pc), 32'h3);

    // ---- reset during LOAD ----
    clear_mem();
    wr(8'd0, ldi(3'd3, 5'd5));
    wr(8'd1, ins(4'h8, 3'd4, 3'd3));
    wr(8'd5, 12'h123);
    do_reset();
    pulse(6);
    chk("midld_state", 32'(dbg_state), 32'h3);
    chk("midld_pc", 32'(dbg_pc), 32'h2);
    do_reset();
    chk("midld_rst_pc", 32'(dbg_pc), 32'h0);
    chk("midld_rst_state", 32'(dbg_state), 32'h0);
    chk("midld_rst_r3", 32'(dut.regs[3]), 32'h0);
    chk("midld_rst_r4", 32'(dut.regs[4]), 32'h0);
    chk("midld_rst_halted", 32'(halted), 32'h0);
    chk("midld_rst_addr", 32'(bus.mem_addr), 32'h0);

    // ---- ALU flags ----
    clear_mem();
    wr(8'd0, ldi(3'd1, 5'd1));
    wr(8'd1, ldi(3'd2, 5'd2));
    wr(8'd2, ins(4'h2, 3'd1, 3'd2));   // SUB R1,R2 -> FFF
    wr(8'd3, ins(4'h1, 3'd1, 3'd2));   // ADD R1,R2 -> 001, carry
    wr(8'd4, ins(4'h3, 3'd1, 3'd2));   // AND -> 0
    wr(8'd5, ins(4'h6, 3'd5, 3'd2));   // MOV R5,R2
    wr(8'd6, ins(4'h4, 3'd1, 3'd2));   // OR -> 2
    wr(8'd7, ins(4'h5, 3'd1, 3'd2));   // XOR -> 0
    do_reset();
    pulse(9);
    chk("sub_r1", 32'(dut.regs[1]), 32'hFFF);
    chk("sub_zcn", 32'({dut.flag_z, dut.flag_n, dut.flag_c}), 32'b010);
    pulse(3);
    chk("addc_r1", 32'(dut.regs[1]), 32'h001);
    chk("addc_zcn", 32'({dut.flag_z, dut.flag_n, dut.flag_c}), 32'b001);
    pulse(3);
    chk("and_r1", 32'(dut.regs[1]), 32'h000);
    chk("and_zcn", 32'({dut.flag_z, dut.flag_n, dut.flag_c}), 32'b100);
    pulse(3);
    chk("mov_r5", 32'(dut.regs[5]), 32'h002);
    chk("mov_zcn", 32'({dut.flag_z, dut.flag_n, dut.flag_c}), 32'b100);
    pulse(3);
    chk("or_r1", 32'(dut.regs[1]), 32'h002);
    chk("or_z", 32'(dut.flag_z), 32'h0);
    pulse(3);
    chk("xor_r1", 32'(dut.regs[1]), 32'h000);
    chk("xor_z", 32'(dut.flag_z), 32'h1);

    // ---- JMP taken (Z) and not taken (!Z) ----
    clear_mem();
    wr(8'd0, ldi(3'd3, 5'd16));
    wr(8'd1, ins(4'h1, 3'd3, 3'd3));
    wr(8'd2, ins(4'h1, 3'd3, 3'd3));   // R3 = 0x40
    wr(8'd3, ldi(3'd1, 5'd0));
    wr(8'd4, ins(4'h2, 3'd1, 3'd1));   // SUB R1,R1
    wr(8'd5, ins(4'hC, 3'd1, 3'd3));   // JMP Z,R3
    wr(8'h40, ins(4'hF, 3'd0, 3'd0));
    do_reset();
    pulse(18);
    chk("jmpz_pc", 32'(dbg_pc), 32'h40);
    chk("jmpz_state", 32'(dbg_state), 32'h0);
    chk("jmpz_zcn", 32'({dut.flag_z, dut.flag_n, dut.flag_c}), 32'b101);
    pulse(3);
    chk("jmpz_halt", 32'(halted), 32'h1);
    chk("jmpz_halt_pc", 32'(dbg_pc), 32'h40);
    wr(8'd5, ins(4'hC, 3'd2, 3'd3));   // JMP !Z,R3
    do_reset();
    pulse(18);
    chk("jmpnz_pc", 32'(dbg_pc), 32'h06);

    // ---- ST then LD ----
    clear_mem();
    wr(8'd0, ldi(3'd2, 5'd16));
    wr(8'd1, ldi(3'd3, 5'd17));
    wr(8'd2, ins(4'h8, 3'd1, 3'd3));   // LD R1,[R3]
    wr(8'd3, ins(4'h9, 3'd1, 3'd2));   // ST R1,[R2]
    wr(8'd4, ins(4'h8, 3'd4, 3'd2));   // LD R4,[R2]
    wr(8'd5, ins(4'hF, 3'd0, 3'd0));
    wr(8'd17, 12'h5A5);
    do_reset();
    pulse(10);
    chk("ld1_r1", 32'(dut.regs[1]), 32'h5A5);
    chk("ld1_pc", 32'(dbg_pc), 32'h3);
    we_before = we_cnt;
    pulse(2);
    chk("st_we_pre", 32'(bus.mem_we), 32'h0);
    @(negedge clk); ce = 1'b1;
    @(negedge clk); ce = 1'b0;
    chk("st_we", 32'(bus.mem_we), 32'h1);
    chk("st_addr", 32'(bus.mem_addr), 32'h10);
    chk("st_wdata", 32'(bus.mem_wdata), 32'h5A5);
    @(negedge clk);
    chk("st_we_clear", 32'(bus.mem_we), 32'h0);
    chk("st_mem", 32'(mem[16]), 32'h5A5);
    pulse(3);
    chk("ld2_state", 32'(dbg_state), 32'h3);
    chk("ld2_r4_pending", 32'(dut.regs[4]), 32'h0);
    chk("ld2_pc", 32'(dbg_pc), 32'h5);
    pulse(1);
    chk("ld2_r4", 32'(dut.regs[4]), 32'h5A5);
    chk("ld2_state_fetch", 32'(dbg_state), 32'h0);
    chk("we_count", 32'(we_cnt - we_before), 32'h1);

    // ---- stack: push/pop, overflow at depth 4 ----
    clear_mem();
    wr(8'd0, ldi(3'd1, 5'd7));
    wr(8'd1, ins(4'hA, 3'd1, 3'd0));
    wr(8'd2, ins(4'hB, 3'd2, 3'd0));
    for (int i = 3; i < 8; i++) wr(8'(i), ins(4'hA, 3'd1, 3'd0));
    do_reset();
    pulse(9);
    chk("pop_r2", 32'(dut.regs[2]), 32'h7);
    chk("pop_sp", 32'(dut.sp), 32'h0);
    pulse(12);
    chk("push4_sp", 32'(dut.sp), 32'h4);
    chk("push4_pc", 32'(dbg_pc), 32'h7);
    chk("push4_fault", 32'(fault), 32'h0);
    pulse(3);
    chk("ovf_fault", 32'(fault), 32'h1);
    chk("ovf_halted", 32'(halted), 32'h1);
    chk("ovf_sp", 32'(dut.sp), 32'h4);
    chk("ovf_pc", 32'(dbg_pc), 32'h7);
    chk("ovf_state", 32'(dbg_state), 32'h4);

    // ---- underflow: POP right after reset ----
    clear_mem();
    wr(8'd0, ins(4'hB, 3'd1, 3'd0));
    do_reset();
    chk("unf_fault_rst", 32'(fault), 32'h0);
    pulse(3);
    chk("unf_fault", 32'(fault), 32'h1);
    chk("unf_halted", 32'(halted), 32'h1);
    chk("unf_pc", 32'(dbg_pc), 32'h0);
    chk("unf_sp", 32'(dut.sp), 32'h0);

    // ---- CALL / RET ----
    clear_mem();
    wr(8'd0, ldi(3'd5, 5'd16));
    wr(8'd1, ins(4'h1, 3'd5, 3'd5));   // R5 = 0x20
    wr(8'd7, ins(4'hD, 3'd0, 3'd5));   // CALL R5
    wr(8'd8, ins(4'hF, 3'd0, 3'd0));
    wr(8'h20, ins(4'hE, 3'd0, 3'd0));  // RET
    do_reset();
    pulse(21);
    chk("call_pre_pc", 32'(dbg_pc), 32'h7);
    pulse(3);
`ifdef CORE_GEN2_CALL_EN
    chk("call_pc", 32'(dbg_pc), 32'h20);
    chk("call_sp", 32'(dut.sp), 32'h1);
    pulse(3);
    chk("ret_pc", 32'(dbg_pc), 32'h8);
    chk("ret_sp", 32'(dut.sp), 32'h0);
`else
    chk("callnop_pc", 32'(dbg_pc), 32'h8);
    chk("callnop_sp", 32'(dut.sp), 32'h0);
`endif
    pulse(3);
    chk("call_halt", 32'(halted), 32'h1);
    chk("call_halt_pc", 32'(dbg_pc), 32'h8);
    chk("call_fault", 32'(fault), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
